// File: rtl/i2s_pkg.sv
// ============================================================================
// Module : i2s_pkg
// Shared I2S frame geometry (transmitter and receiver): 32-bit slots, 64-bit frame.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int SLOT_BITS     = 32;
    localparam int FRAME_BITS    = 2 * SLOT_BITS;
    localparam int LEFT_MSB_IDX  = 1;
    localparam int RIGHT_MSB_IDX = SLOT_BITS + LEFT_MSB_IDX;
    localparam int WS_RISE_IDX   = SLOT_BITS - 1;
    localparam int WS_FALL_IDX   = FRAME_BITS - 1;

    typedef logic [$clog2(FRAME_BITS)-1:0] bit_idx_t;

    // WS flips one bit ahead of each channel's MSB.
    function automatic logic ws_for_idx(input bit_idx_t idx);
        return (int'(idx) >= WS_RISE_IDX) && (int'(idx) < WS_FALL_IDX);
    endfunction

    function automatic logic in_slot(input bit_idx_t idx, input int msb_idx, input int width);
        return (int'(idx) >= msb_idx) && (int'(idx) < msb_idx + width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// Module : i2s_clk_gen
// Divides clk_in down to the I2S bit clock and flags the cycle of each edge.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2s_clk_gen #(
    parameter int SCLK_DIV = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic sclk_out,
    output logic rise_out,
    output logic fall_out
);

    localparam int DIV_W = $clog2(SCLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             w_wrap;

    assign w_wrap = (r_div == DIV_W'(SCLK_DIV - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    // Strobes are high in the cycle whose closing edge toggles sclk.
    assign rise_out = w_wrap & ~r_sclk;
    assign fall_out = w_wrap &  r_sclk;
    assign sclk_out = r_sclk;

endmodule

`default_nettype wire

// File: rtl/i2s_transmitter.sv
// ============================================================================
// Module : i2s_transmitter
// I2S master transmitter with one-deep valid/ready holding register.
// Optional macro I2S_TX_UNDERRUN_COUNT_EN adds a saturating underrun counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int SCLK_DIV = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] left_in,
    input  logic [WIDTH-1:0] right_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             sclk_out,
    output logic             ws_out,
    output logic             sdata_out,
    output logic             frame_start_out,
    output logic             underrun_out
`ifdef I2S_TX_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]      underrun_count_out
`endif
);

    logic             w_rise;
    logic             w_fall;
    logic             w_load;
    logic             w_accept;
    logic             w_nxt_left;
    logic             w_nxt_right;
    logic             w_cur_left;
    logic             w_cur_right;
    bit_idx_t         w_next_idx;

    bit_idx_t         r_bit_idx;
    logic             r_ws;
    logic             r_sdata;
    logic             r_frame_start;
    logic             r_underrun;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_hold_l;
    logic [WIDTH-1:0] r_hold_r;
    logic [WIDTH-1:0] r_sh_l;
    logic [WIDTH-1:0] r_sh_r;

    i2s_clk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_clk_gen (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sclk_out (sclk_out),
        .rise_out (w_rise),
        .fall_out (w_fall)
    );

    assign w_next_idx  = r_bit_idx + 1'b1;
    assign w_load      = w_fall && (w_next_idx == '0);
    assign w_accept    = valid_in && !r_hold_full;
    assign w_nxt_left  = in_slot(w_next_idx, LEFT_MSB_IDX, WIDTH);
    assign w_nxt_right = in_slot(w_next_idx, RIGHT_MSB_IDX, WIDTH);
    assign w_cur_left  = in_slot(r_bit_idx, LEFT_MSB_IDX, WIDTH);
    assign w_cur_right = in_slot(r_bit_idx, RIGHT_MSB_IDX, WIDTH);

    // The MSB of each shift register is driven on the fall entering a data bit;
    // the register advances at the following rise, ready for the next fall.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_bit_idx     <= bit_idx_t'(WS_FALL_IDX);
            r_ws          <= 1'b0;
            r_sdata       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_sh_l        <= '0;
            r_sh_r        <= '0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;

            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= left_in;
                r_hold_r    <= right_in;
            end

            if (w_fall) begin
                r_bit_idx <= w_next_idx;
                r_ws      <= ws_for_idx(w_next_idx);
                r_sdata   <= 1'b0;
                if (w_load) begin
                    r_frame_start <= 1'b1;
                    // An accept in this same cycle only lands in the holding register.
                    if (r_hold_full) begin
                        r_sh_l      <= r_hold_l;
                        r_sh_r      <= r_hold_r;
                        r_hold_full <= 1'b0;
                    end else begin
                        r_sh_l      <= '0;
                        r_sh_r      <= '0;
                        r_underrun  <= 1'b1;
                    end
                end else if (w_nxt_left) begin
                    r_sdata <= r_sh_l[WIDTH-1];
                end else if (w_nxt_right) begin
                    r_sdata <= r_sh_r[WIDTH-1];
                end
            end

            if (w_rise) begin
                if (w_cur_left) begin
                    r_sh_l <= {r_sh_l[WIDTH-2:0], 1'b0};
                end
                if (w_cur_right) begin
                    r_sh_r <= {r_sh_r[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_COUNT_EN
    logic [15:0] r_urun_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_urun_cnt <= '0;
        end else if (r_underrun && (r_urun_cnt != 16'hFFFF)) begin
            r_urun_cnt <= r_urun_cnt + 16'd1;
        end
    end

    assign underrun_count_out = r_urun_cnt;
`endif

    assign ready_out       = ~r_hold_full;
    assign ws_out          = r_ws;
    assign sdata_out       = r_sdata;
    assign frame_start_out = r_frame_start;
    assign underrun_out    = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_transmitter.sv
// ============================================================================
// Module : tb_i2s_transmitter
// Directed bench for i2s_transmitter (WIDTH=24, SCLK_DIV=16, 2048 clk per frame).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_i2s_transmitter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [23:0] left_in = '0;
    logic [23:0] right_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        sclk_out;
    logic        ws_out;
    logic        sdata_out;
    logic        frame_start_out;
    logic        underrun_out;
`ifdef I2S_TX_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] cap_l, cap_r, sim_l, sim_r;
    int cap_extra, cap_ws_err, cap_acc, cap_ur, cap_fs, cap_rdy;
    int pat;

    i2s_transmitter #(
        .WIDTH    (24),
        .SCLK_DIV (16)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .left_in         (left_in),
        .right_in        (right_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .sclk_out        (sclk_out),
        .ws_out          (ws_out),
        .sdata_out       (sdata_out),
        .frame_start_out (frame_start_out),
        .underrun_out    (underrun_out)
`ifdef I2S_TX_UNDERRUN_COUNT_EN
        ,
        .underrun_count_out (underrun_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pat_l(input int k);
        return 24'hA00000 + 24'(k);
    endfunction

    function automatic logic [23:0] pat_r(input int k);
        return 24'h0C0000 + 24'(k * 7);
    endfunction

    // Reset for n cycles, check reset state, then check the first fall/load lands on cycle 32.
    task automatic do_reset(input int n);
        rst_in = 1'b1;
        repeat (n) step();
        chk("rst_sclk", sclk_out, 0);
        chk("rst_ws", ws_out, 0);
        chk("rst_sdata", sdata_out, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_fs", frame_start_out, 0);
        chk("rst_ur", underrun_out, 0);
        rst_in = 1'b0;
        repeat (31) step();
        chk("pre_fall_sclk", sclk_out, 1);
        chk("pre_fall_fs", frame_start_out, 0);
        step();
        chk("fall_sclk", sclk_out, 0);
        chk("fall_fs", frame_start_out, 1);
        chk("fall_ur", underrun_out, 1);
    endtask

    // Starts on a load cycle, ends on the next load cycle. vmode 1 offers sim_l/r
    // for one cycle right after the load, vmode 2 offers it in the cycle before the next load.
    task automatic capture_frame(input bit stream, input int vmode);
        bit acc;
        int k;
        cap_l = '0; cap_r = '0;
        cap_extra = 0; cap_ws_err = 0; cap_acc = 0; cap_ur = 0; cap_fs = 0; cap_rdy = 0;
        for (int o = 0; o < 2048; o++) begin
            if (o % 32 == 16) begin
                k = o / 32;
                if (ws_out !== ((k >= 31 && k <= 62) ? 1'b1 : 1'b0)) cap_ws_err++;
                if (k >= 1 && k <= 24)       cap_l = {cap_l[22:0], sdata_out};
                else if (k >= 33 && k <= 56) cap_r = {cap_r[22:0], sdata_out};
                else if (sdata_out !== 1'b0) cap_extra++;
            end
            if (o > 0) begin
                cap_ur += int'(underrun_out);
                cap_fs += int'(frame_start_out);
            end
            cap_rdy += int'(ready_out);
            if ((vmode == 1 && o == 0) || (vmode == 2 && o == 2047)) begin
                valid_in = 1'b1; left_in = sim_l; right_in = sim_r;
            end
            acc = valid_in && ready_out;
            step();
            if (vmode != 0) valid_in = 1'b0;
            if (acc) begin
                cap_acc++;
                if (stream) begin
                    pat++;
                    left_in = pat_l(pat); right_in = pat_r(pat);
                end
            end
        end
    endtask

    initial begin
        // Reset and idle frames
        do_reset(2);
        capture_frame(0, 0);
        chk("idle_left", cap_l, 0);
        chk("idle_right", cap_r, 0);
        chk("idle_extra", cap_extra, 0);
        chk("idle_ws", cap_ws_err, 0);
        chk("idle_midframe_ur", cap_ur, 0);
        chk("idle_midframe_fs", cap_fs, 0);
        chk("idle_end_fs", frame_start_out, 1);
        chk("idle_end_ur", underrun_out, 1);

        // Directed pair accepted right after a load, sent in the next frame
        sim_l = 24'hA5C3F0; sim_r = 24'h123456;
        capture_frame(0, 1);
        chk("dir_acc", cap_acc, 1);
        chk("dir_silent_left", cap_l, 0);
        chk("dir_load_ur", underrun_out, 0);
        chk("dir_load_fs", frame_start_out, 1);
        capture_frame(0, 0);
        chk("dir_left", cap_l, 24'hA5C3F0);
        chk("dir_right", cap_r, 24'h123456);
        chk("dir_extra", cap_extra, 0);
        chk("dir_ws", cap_ws_err, 0);
        chk("dir_end_ur", underrun_out, 1);

        // Offer in the load cycle itself with the holding register empty
        sim_l = 24'h3C3C3C; sim_r = 24'hC3C3C3;
        capture_frame(0, 2);
        chk("sim_load_fs", frame_start_out, 1);
        chk("sim_load_ur", underrun_out, 1);
        chk("sim_load_ready", ready_out, 0);
        capture_frame(0, 0);
        chk("sim_silent_left", cap_l, 0);
        chk("sim_silent_right", cap_r, 0);
        chk("sim_next_ur", underrun_out, 0);
        capture_frame(0, 0);
        chk("sim_left", cap_l, 24'h3C3C3C);
        chk("sim_right", cap_r, 24'hC3C3C3);
        chk("sim_end_ur", underrun_out, 1);

        // Continuous stream for 10 frames
        pat = 0;
        left_in = pat_l(0); right_in = pat_r(0); valid_in = 1'b1;
        capture_frame(1, 0);
        chk("strm0_acc", cap_acc, 1);
        chk("strm0_end_ur", underrun_out, 0);
        for (int i = 1; i <= 10; i++) begin
            capture_frame(1, 0);
            chk("strm_acc", cap_acc, 1);
            chk("strm_rdy_cycles", cap_rdy, 1);
            chk("strm_mid_ur", cap_ur, 0);
            chk("strm_end_ur", underrun_out, 0);
            chk("strm_left", cap_l, pat_l(i - 1));
            chk("strm_right", cap_r, pat_r(i - 1));
        end
        valid_in = 1'b0;
        capture_frame(0, 0);
        chk("strm_tail_left", cap_l, pat_l(10));
        chk("strm_tail_ur", underrun_out, 1);

        // Reset at bit 40 with a pair held
        valid_in = 1'b1; left_in = 24'h7E7E7E; right_in = 24'h0F0F0F;
        step();
        valid_in = 1'b0;
        chk("hold_ready", ready_out, 0);
        repeat (1279 + 16) step();
        chk("bit40_ws", ws_out, 1);
        chk("bit40_sclk", sclk_out, 1);
        do_reset(1);
        capture_frame(0, 0);
        chk("post_rst_left", cap_l, 0);
        chk("post_rst_right", cap_r, 0);
        chk("post_rst_end_ur", underrun_out, 1);

`ifdef I2S_TX_UNDERRUN_COUNT_EN
        do_reset(2);
        repeat (4) capture_frame(0, 0);
        step(); step();
        chk("cnt_five", underrun_count_out, 16'd5);
        force dut.r_urun_cnt = 16'hFFFE;
        step();
        release dut.r_urun_cnt;
        repeat (2) capture_frame(0, 0);
        step(); step();
        chk("cnt_sat", underrun_count_out, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S master transmitter: drives an external I2S DAC/amp from processed audio on the 100 MHz system clock.
- Mirror of the existing mic-side I2S receiver. Generates sclk/ws itself, serializes a stereo sample pair per frame, and accepts samples through a one-deep valid/ready holding register.
- Sits after the pitch-shift/bufferizer path as an alternative to the PDM speaker output.

Parameters:
- WIDTH, 24, audio bits per channel, two's complement; legal range 8..31.
- SCLK_DIV, 16, clk_in cycles per sclk half-period; legal range 2..1023. Default gives 3.125 MHz sclk and a 48.828 kHz frame rate.

Ports:
- clk_in  input  1  system clock (100 MHz)
- rst_in  input  1  synchronous, active-high reset
- left_in  input  WIDTH  left-channel sample
- right_in  input  WIDTH  right-channel sample
- valid_in  input  1  sample pair valid
- ready_out  output  1  holding register empty; transfer when valid_in && ready_out
- sclk_out  output  1  I2S bit clock
- ws_out  output  1  word select; 0 = left, 1 = right
- sdata_out  output  1  serial data, MSB first
- frame_start_out  output  1  one-cycle pulse at each frame load
- underrun_out  output  1  one-cycle pulse when a frame loads with the holding register empty

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous and active-high.
- Reset values: sclk_out=0, ws_out=0, sdata_out=0, ready_out=1, frame_start_out=0, underrun_out=0. Internally: div counter=0, bit_idx=63, holding register empty, shift register=0.
- Clock divider:
  - div counts 0..SCLK_DIV-1; at SCLK_DIV-1 it wraps and sclk_out toggles.
  - A "fall event" is the cycle in which sclk_out is driven 1->0.
- Bit sequencing:
  - On each fall event, bit_idx advances modulo 64 (32-bit slot per channel, 64-bit frame).
  - ws_out and sdata_out update registered in the same cycle as sclk_out falls, so they are stable at the receiver's rising edge.
- Word select: ws_out=1 for bit_idx 31..62; ws_out=0 for bit_idx 63 and 0..30. WS therefore leads the MSB by one bit (standard I2S).
- Serial data:
  - Left channel: bit_idx 1..WIDTH -> left[WIDTH-bit_idx].
  - Right channel: bit_idx 33..32+WIDTH -> right[WIDTH-(bit_idx-32)].
  - All other bit positions drive 0.
- Frame load (fall event entering bit_idx=0):
  - If the holding register is full: its contents go to the shift registers, it is marked empty, and frame_start_out pulses.
  - If the holding register is empty: the shift registers load zeros (silence), and frame_start_out and underrun_out both pulse.
- Handshake:
  - ready_out = holding register empty, registered.
  - An accepted pair is transmitted in the next frame; latency ≤ 1 frame + 1 bit.
  - While not ready, valid_in is ignored; data is not required to be held stable, and no data is lost because it was never accepted.
- Simultaneous accept and load (holding register empty, valid_in=1 in the load cycle): the load sees empty (underrun), and the new pair is captured into the holding register for the next frame. ready_out falls the following cycle.
- First fall after reset occurs at cycle 2*SCLK_DIV and loads frame 0.
- Reset mid-frame: outputs return to reset values within one cycle, holding data is discarded, and no partial-frame completion is attempted.

Optional Feature:
- Macro I2S_TX_UNDERRUN_COUNT_EN.
- Defined: adds output underrun_count_out [15:0]. It increments on each underrun_out pulse, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port does not exist and no counter logic is generated; underrun_out is unaffected.

Decomposition:
- Package i2s_pkg: SLOT_BITS=32, FRAME_BITS=64, bit_idx_t (logic [5:0]), LEFT_MSB_IDX=1, RIGHT_MSB_IDX=33, WS_RISE_IDX=31, WS_FALL_IDX=63. The receiver is to be migrated to the same package.
- Sub-module i2s_clk_gen: divider producing sclk_out plus rise/fall strobes, parameterized by SCLK_DIV. It is shared with the receiver.

Test Plan:
- Reset, then idle with valid_in=0. Expected: first sclk_out fall at cycle 32 with SCLK_DIV=16; ws_out period 64 sclk; sdata_out stays 0; underrun_out pulses once per frame (every 2048 clk cycles).
- Load left=24'hA5C3F0, right=24'h123456, then capture 64 bits on sclk_out rise edges. Expected: ws_out high at bit 31; left bits 1..24 = A5C3F0 MSB-first; right bits 33..56 = 123456; remaining bits 0.
- Hold valid_in=1 with an incrementing pattern for 10 frames. Expected: exactly one transfer per frame; ready_out low between transfers; zero underruns; each frame carries the next sample in order.
- Assert valid_in only in the load cycle with the holding register empty. Expected: that frame is silent with underrun_out=1; the pair appears in the following frame.
- Assert rst_in at bit_idx=40 mid-frame. Expected: next cycle sclk_out=ws_out=sdata_out=0 and ready_out=1; previously held data is never transmitted.
- With I2S_TX_UNDERRUN_COUNT_EN, run 5 idle frames, then preload the counter near 16'hFFFF by force. Expected: count=5 after the idle frames; the forced counter saturates at 16'hFFFF.
